// File: rtl/c_pkg.sv
// Shared types and constants for the RV32IC fetch front end.
package c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // A parcel whose low two bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] op);
        return (op != 2'b11);
    endfunction

endpackage

// File: rtl/c_fetch_pc.sv
// Fetch PC generator: one-outstanding req/gnt/rvalid fetch, presents (pc, word)
// parcels to the realigner, handles stall and execute-stage redirects.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | imem_req_o high at pc, waiting for gnt
// WAIT  | granted, waiting for rvalid (drop = discard this response)
// HOLD  | parcel live on pc_o/inst_o until consumed or redirected
module c_fetch_pc
    import c_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_for_branch,
    input  logic [31:0] branch_target,
    input  logic        stall_pc,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         drop;
    logic         req_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         valid_q;

    logic [31:0]  target_al;
    logic [31:0]  pc_next;

    assign target_al = branch_target & ~32'd1;
    assign pc_next   = is_compressed(inst_q[1:0]) ? (pc + 32'd2) : (pc + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_for_branch) begin
                        pc <= target_al;
                    end
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (sel_for_branch) begin
                        pc <= target_al;
                        // A grant coinciding with the redirect is already in flight.
                        if (imem_gnt_i) begin
                            drop  <= 1'b1;
                            state <= WAIT;
                            req_q <= 1'b0;
                        end
                    end else if (imem_gnt_i) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (sel_for_branch) begin
                        pc <= target_al;
                        if (imem_rvalid_i) begin
                            drop  <= 1'b0;
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            inst_q  <= imem_rdata_i;
                            pc_q    <= pc;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sel_for_branch) begin
                        pc      <= target_al;
                        valid_q <= 1'b0;
                        inst_q  <= NOP_INST;
                        state   <= REQ;
                        req_q   <= 1'b1;
                    end else if (!stall_pc) begin
                        pc      <= pc_next;
                        valid_q <= 1'b0;
                        inst_q  <= NOP_INST;
                        state   <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: doc/c_fetch_pc.md
Name: c_fetch_pc

Overview:
- PC generator and instruction-memory fetch requester for the RV32IC front end.
- Produces the halfword-granular fetch PC and runs a req/gnt/rvalid handshake with instruction memory.
- Presents each fetched parcel (pc, 32-bit word) to the downstream misalignment realigner.
- Honours the realigner's stall and the execute stage's branch/jump redirect; discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be halfword aligned.
- NOP_INST, 32'h0000_0013, word presented on inst_o whenever inst_valid_o is low.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sel_for_branch  input  1  redirect request from execute (branch taken / jump).
- branch_target  input  32  redirect target; bit 0 ignored.
- stall_pc  input  1  realigner stall; hold the current PC and output.
- imem_req_o  output  1  fetch request to instruction memory.
- imem_addr_o  output  32  fetch address = pc register, halfword aligned.
- imem_gnt_i  input  1  memory accepted the request this cycle.
- imem_rvalid_i  input  1  response data valid; at least 1 cycle after the gnt.
- imem_rdata_i  input  32  response word: bits [15:0] at imem_addr_o, bits [31:16] at imem_addr_o+2.
- pc_o  output  32  PC of the presented parcel.
- inst_o  output  32  presented word (to the realigner's inst_in).
- inst_valid_o  output  1  pc_o/inst_o hold a live parcel.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, drop=0.
  - imem_req_o=0, imem_addr_o=RESET_PC, pc_o=RESET_PC, inst_o=NOP_INST, inst_valid_o=0.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: one cycle after reset release; go to REQ.
  - REQ:
    - imem_req_o=1, imem_addr_o=pc; addr stays stable until gnt.
    - gnt -> WAIT.
  - WAIT:
    - imem_req_o=0.
    - rvalid & !drop -> capture rdata into the output register and pc into pc_o; go to HOLD.
    - rvalid & drop -> clear drop, go to REQ; data discarded, inst_valid_o stays 0.
  - HOLD:
    - inst_valid_o=1.
    - stall_pc=1 -> hold everything.
    - stall_pc=0 -> the parcel is consumed this cycle. Next pc = pc + 2 if inst_o[1:0] != 2'b11, else pc + 4 (32-bit adder, wraps mod 2^32). Go to REQ; inst_valid_o=0 from the next cycle.
- Redirect (sel_for_branch=1), highest priority; pc <= {branch_target[31:1],1'b0} in every state:
  - REQ: abandon any ungranted request; the next cycle re-requests at the target. gnt in the same cycle as the redirect -> the request is counted as in flight: set drop, go to WAIT.
  - WAIT: set drop (unless rvalid this cycle, which is simply discarded); go to REQ on the drop-response.
  - HOLD: invalidate the parcel (inst_valid_o=0 next cycle), go to REQ; stall_pc ignored.
  - IDLE: load target, go to REQ.
- Max one outstanding request; drop covers at most one stale response.
- rvalid while not in WAIT is a protocol error; ignore it.
- inst_o = NOP_INST whenever inst_valid_o=0, so the realigner sees a NOP bubble.
- Latency: back-to-back sequential parcels with zero-wait memory (gnt same cycle, rvalid next) every 3 cycles (REQ, WAIT, HOLD).
- Reset asserted mid-transaction: immediate return to reset values. A late rvalid after reset release arrives while in IDLE/REQ and is ignored.

Decomposition:
- Shared package c_pkg:
  - fetch state enum (IDLE/REQ/WAIT/HOLD, 2-bit).
  - NOP constant 32'h0000_0013.
  - function is_compressed(logic [1:0]) returning bits != 2'b11.
- No sub-module; the next-PC adder/mux is inline combinational logic.

Test Plan:
- Reset release, RESET_PC=32'h100, memory returns 32'h0000_4501 (compressed) -> first imem_addr_o=0x100; parcel pc_o=0x100 valid; next request addr=0x102.
- Word 32'h0050_0093 (addi, [1:0]=11) at 0x200 -> next request addr=0x204; inst_o=0x00500093 while valid.
- HOLD with stall_pc high 3 cycles -> pc_o/inst_o/inst_valid_o constant; no imem_req_o; after release the next request at the expected address.
- Redirect to 0x400 in WAIT, then rvalid data 0xDEADBEEF -> inst_valid_o never rises for 0xDEADBEEF; next request addr=0x400.
- Redirect to 0x301 in the same cycle as gnt -> response dropped; request addr=0x300 (bit 0 cleared).
- rst_n pulled low in WAIT -> outputs return to reset values asynchronously; stray rvalid after release ignored; first request at RESET_PC.
